mem_master: RTL

Bus initiator that drives the single data/instruction memory port of the CPU. Accepts instruction-fetch and load/store requests from the pipeline and serialises them onto one memory port. Runs the ce/we/sel/data_ready handshake, returns read data with a one-cycle done pulse, and raises a stall request while any access is outstanding. Sits between the pipeline (IF and MEM stages) and the memory model.

---
 rtl/mem_master_pkg.sv | 38 +++
 rtl/mem_master.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and constants for the memory-port bus initiator.
package mem_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned WAIT_W = 8;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [SEL_W-1:0]  SEL_ALL   = '1;

    typedef enum logic [2:0] {
        MEM_IDLE  = 3'd0,
        MEM_IF_RD = 3'd1,
        MEM_DM_RD = 3'd2,
        MEM_DM_WR = 3'd3,
        MEM_RESP  = 3'd4
    } mem_state_e;

    // Request payload presented to the memory port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // True for the states that wait on read data
    function automatic logic is_read_state(input mem_state_e st);
        return (st == MEM_IF_RD) || (st == MEM_DM_RD);
    endfunction

endpackage

// File: rtl/mem_master.sv
// Serialises instruction fetches and loads/stores onto one memory port.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_sel,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        stallreq,
    output logic        bus_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        data_ready
);

    mem_state_e          state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                served_dm;
    logic [DATA_W-1:0]   result;
    mem_req_t            req_c;

    // Data side wins arbitration; a fetch always reads all four lanes
    always_comb begin
        req_c = '{we: WRITE_DISABLE, addr: if_addr, sel: SEL_ALL, wdata: mem_wdata};
        if (dm_req) begin
            req_c = '{we: dm_we, addr: dm_addr, sel: dm_sel, wdata: dm_wdata};
        end
    end

    // Access sequencer: latches a request, runs the port handshake, pulses done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MEM_IDLE;
            wait_cnt  <= '0;
            served_dm <= 1'b0;
            result    <= ZERO_WORD;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            bus_err   <= 1'b0;
            mem_ce    <= CHIP_DISABLE;
            mem_we    <= WRITE_DISABLE;
            mem_addr  <= '0;
            mem_sel   <= '0;
            mem_wdata <= ZERO_WORD;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    wait_cnt <= '0;
                    if (dm_req || if_req) begin
                        served_dm <= dm_req;
                        mem_ce    <= CHIP_ENABLE;
                        mem_we    <= req_c.we;
                        mem_addr  <= req_c.addr;
                        mem_sel   <= req_c.sel;
                        mem_wdata <= req_c.wdata;
                        if (!dm_req)
                            state <= MEM_IF_RD;
                        else if (dm_we)
                            state <= MEM_DM_WR;
                        else
                            state <= MEM_DM_RD;
                    end
                end
                MEM_IF_RD, MEM_DM_RD: begin
                    if (data_ready) begin
                        result  <= mem_rdata;
                        state   <= MEM_RESP;
                        mem_ce  <= CHIP_DISABLE;
                        mem_we  <= WRITE_DISABLE;
                        if_done <= ~served_dm;
                        dm_done <= served_dm;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        result  <= ZERO_WORD;
                        bus_err <= 1'b1;
                        state   <= MEM_RESP;
                        mem_ce  <= CHIP_DISABLE;
                        mem_we  <= WRITE_DISABLE;
                        if_done <= ~served_dm;
                        dm_done <= served_dm;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                MEM_DM_WR: begin
                    state   <= MEM_RESP;
                    mem_ce  <= CHIP_DISABLE;
                    mem_we  <= WRITE_DISABLE;
                    if_done <= 1'b0;
                    dm_done <= 1'b1;
                end
                MEM_RESP: begin
                    state <= MEM_IDLE;
                end
                default: begin
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

    // One result register feeds both return paths
    assign if_inst  = result;
    assign dm_rdata = result;

    // Stall while busy, or in idle as soon as any side is asking
    assign stallreq = (state == MEM_IDLE) ? (if_req | dm_req)
                                          : (state != MEM_RESP);

endmodule
